// File: rtl/fifo_pkg.sv
// Shared helpers and configuration checks for the synchronous FIFO family.
package fifo_pkg;

  // Smallest legal depth; a one-entry FIFO cannot tell full from almost-full.
  localparam int unsigned FIFO_MIN_DEPTH = 32'd2;

  // Width needed to hold an occupancy value of 0..depth inclusive.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 32'sd1);
  endfunction

  // Advance a pointer by one and wrap at depth-1; depth need not be a power of 2.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    int unsigned nxt;
    if (ptr == depth - 32'd1) begin
      nxt = 32'd0;
    end else begin
      nxt = ptr + 32'd1;
    end
    return nxt;
  endfunction

  // Depth and both almost thresholds must fall inside 1..depth-1.
  function automatic bit thresh_ok(input int depth, input int af, input int ae);
    return (depth >= int'(FIFO_MIN_DEPTH)) &&
           (af >= 32'sd1) && (af <= depth - 32'sd1) &&
           (ae >= 32'sd1) && (ae <= depth - 32'sd1);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];

  // Capture the write word; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Pointers never exceed DEPTH-1, so the read index is always in range.
  assign rdata = mem_r[raddr];

endmodule

// File: rtl/fifo_sync_v2.sv
// Single-clock FIFO with arbitrary depth, almost flags, occupancy count,
// optional first-word-fall-through output, flush and sticky error flags.
module fifo_sync_v2
  import fifo_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int AF_THRESH  = FIFO_DEPTH - 1,
  parameter int AE_THRESH  = 1,
  parameter bit FWFT       = 1'b0,
  parameter int CNT_W      = cnt_width(FIFO_DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [FIFO_WIDTH-1:0] data_in,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic [FIFO_WIDTH-1:0] data_out,
  output logic                  data_valid,
  output logic                  wr_ack,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  full,
  output logic                  empty,
  output logic                  almostfull,
  output logic                  almostempty,
  output logic [CNT_W-1:0]      count,
  output logic                  ovf_sticky,
  output logic                  udf_sticky
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam bit CFG_OK = thresh_ok(FIFO_DEPTH, AF_THRESH, AE_THRESH);

  generate
    if (!CFG_OK) begin : g_cfg_err
      $error("fifo_sync_v2: depth or almost thresholds out of range");
    end
  endgenerate

  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      count_r, count_nxt_s;
  logic                  wr_ack_r, overflow_r, underflow_r;
  logic                  ovf_sticky_r, udf_sticky_r;
  logic                  full_s, empty_s;
  logic                  wr_acc_s, rd_acc_s, ovf_evt_s, udf_evt_s;
  logic [FIFO_WIDTH-1:0] rd_data_s;

  // Occupancy flags decode straight from the registered count.
  assign full_s      = (count_r == CNT_W'(FIFO_DEPTH));
  assign empty_s     = (count_r == {CNT_W{1'b0}});
  assign full        = full_s;
  assign empty       = empty_s;
  assign almostfull  = (count_r >= CNT_W'(AF_THRESH)) && !full_s;
  assign almostempty = (count_r <= CNT_W'(AE_THRESH)) && !empty_s;
  assign count       = count_r;

  // Accept/reject decisions; flush masks both requests for the cycle.
  always_comb begin
    wr_acc_s  = 1'b0;
    rd_acc_s  = 1'b0;
    ovf_evt_s = 1'b0;
    udf_evt_s = 1'b0;
    if (flush) begin
      wr_acc_s  = 1'b0;
      rd_acc_s  = 1'b0;
    end else begin
      wr_acc_s  = wr_en && !full_s;
      rd_acc_s  = rd_en && !empty_s;
      ovf_evt_s = wr_en && full_s;
      udf_evt_s = rd_en && empty_s;
    end
  end

  // Up/down occupancy update from the accepted operations.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, rd_acc_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, count and the one-cycle status pulses; flush zeroes them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      wr_ack_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else if (flush) begin
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      wr_ack_r    <= 1'b0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= PTR_W'(ptr_next(int'(wr_ptr_r), FIFO_DEPTH));
      end
      if (rd_acc_s) begin
        rd_ptr_r <= PTR_W'(ptr_next(int'(rd_ptr_r), FIFO_DEPTH));
      end
      count_r     <= count_nxt_s;
      wr_ack_r    <= wr_acc_s;
      overflow_r  <= ovf_evt_s;
      underflow_r <= udf_evt_s;
    end
  end

  // Sticky error latches: a new event beats a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_sticky_r <= 1'b0;
      udf_sticky_r <= 1'b0;
    end else begin
      if (ovf_evt_s) begin
        ovf_sticky_r <= 1'b1;
      end else if (err_clr) begin
        ovf_sticky_r <= 1'b0;
      end
      if (udf_evt_s) begin
        udf_sticky_r <= 1'b1;
      end else if (err_clr) begin
        udf_sticky_r <= 1'b0;
      end
    end
  end

  assign wr_ack     = wr_ack_r;
  assign overflow   = overflow_r;
  assign underflow  = underflow_r;
  assign ovf_sticky = ovf_sticky_r;
  assign udf_sticky = udf_sticky_r;

  fifo_mem #(
    .WIDTH (FIFO_WIDTH),
    .DEPTH (FIFO_DEPTH),
    .AW    (PTR_W)
  ) u_mem (
    .clk   (clk),
    .we    (wr_acc_s),
    .waddr (wr_ptr_r),
    .wdata (data_in),
    .raddr (rd_ptr_r),
    .rdata (rd_data_s)
  );

  generate
    if (FWFT) begin : g_fwft
      // Head of queue is always presented; valid whenever anything is stored.
      assign data_out   = rd_data_s;
      assign data_valid = !empty_s;
    end else begin : g_regread
      logic [FIFO_WIDTH-1:0] data_out_r;
      logic                  data_valid_r;

      // Registered read: word lands one cycle after an accepted pop.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_out_r   <= {FIFO_WIDTH{1'b0}};
          data_valid_r <= 1'b0;
        end else if (flush) begin
          data_valid_r <= 1'b0;
        end else begin
          data_valid_r <= rd_acc_s;
          if (rd_acc_s) begin
            data_out_r <= rd_data_s;
          end
        end
      end

      assign data_out   = data_out_r;
      assign data_valid = data_valid_r;
    end
  endgenerate

endmodule

// File: tb/tb_fifo_sync_v2.sv
// Directed bench: DUT A is depth 8 registered-read, DUT B is depth 5 FWFT.
// Expected read data goes into per-DUT queues; monitors pop on output.
module tb_fifo_sync_v2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          total = 0;
  int          bad = 0;

  // DUT A signals
  logic [15:0] din_a = 16'h0, dout_a;
  logic        wr_a = 1'b0, rd_a = 1'b0, flush_a = 1'b0, clr_a = 1'b0;
  logic        dv_a, ack_a, ovf_a, udf_a, full_a, empty_a, af_a, ae_a, ovfs_a, udfs_a;
  logic [3:0]  cnt_a;

  // DUT B signals
  logic [15:0] din_b = 16'h0, dout_b;
  logic        wr_b = 1'b0, rd_b = 1'b0;
  logic        dv_b, ack_b, ovf_b, udf_b, full_b, empty_b, af_b, ae_b, ovfs_b, udfs_b;
  logic [2:0]  cnt_b;

  logic [15:0] q_a[$];
  logic [15:0] q_b[$];

  always #5 clk = ~clk;

  fifo_sync_v2 u_a (
    .clk(clk), .rst_n(rst_n), .data_in(din_a), .wr_en(wr_a), .rd_en(rd_a),
    .flush(flush_a), .err_clr(clr_a), .data_out(dout_a), .data_valid(dv_a),
    .wr_ack(ack_a), .overflow(ovf_a), .underflow(udf_a), .full(full_a),
    .empty(empty_a), .almostfull(af_a), .almostempty(ae_a), .count(cnt_a),
    .ovf_sticky(ovfs_a), .udf_sticky(udfs_a)
  );

  fifo_sync_v2 #(.FIFO_WIDTH(16), .FIFO_DEPTH(5), .FWFT(1'b1)) u_b (
    .clk(clk), .rst_n(rst_n), .data_in(din_b), .wr_en(wr_b), .rd_en(rd_b),
    .flush(1'b0), .err_clr(1'b0), .data_out(dout_b), .data_valid(dv_b),
    .wr_ack(ack_b), .overflow(ovf_b), .underflow(udf_b), .full(full_b),
    .empty(empty_b), .almostfull(af_b), .almostempty(ae_b), .count(cnt_b),
    .ovf_sticky(ovfs_b), .udf_sticky(udfs_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor A: every registered-read output pulse must match the queue head.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && dv_a) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_valid", {16'h0, dout_a}, 32'hdead);
        end else begin
          chk("a_rd_data", {16'h0, dout_a}, {16'h0, q_a.pop_front()});
        end
      end
    end
  end

  // Monitor B: in FWFT mode the word being popped is on data_out before the edge.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && rd_b && dv_b) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_pop", {16'h0, dout_b}, 32'hdead);
        end else begin
          chk("b_rd_data", {16'h0, dout_b}, {16'h0, q_b.pop_front()});
        end
      end
    end
  end

  initial begin
    // ---------------- reset state ----------------
    tick(); tick();
    chk("rst_flags_a", {cnt_a, empty_a, full_a, af_a, ae_a, dv_a, ack_a, ovf_a, udf_a, ovfs_a, udfs_a},
        {4'd0, 1'b1, 9'b0});
    chk("rst_dout_a", {16'h0, dout_a}, 32'h0);
    chk("rst_b", {cnt_b, empty_b, dv_b}, {3'd0, 1'b1, 1'b0});
    #2 rst_n = 1'b1;
    tick();

    // ---------------- A: fill 1..8 ----------------
    for (int i = 1; i <= 8; i++) begin
      wr_a = 1'b1; din_a = 16'(i);
      tick();
      chk("fill_ack", {31'h0, ack_a}, 32'd1);
      chk("fill_cnt", {28'h0, cnt_a}, 32'(i));
      chk("fill_flags", {29'h0, af_a, full_a, ae_a}, {29'h0, (i == 7), (i == 8), (i == 1)});
    end
    din_a = 16'h9;
    tick();
    wr_a = 1'b0;
    chk("ovf_pulse", {29'h0, ovf_a, ack_a, ovfs_a}, {29'h0, 3'b101});
    chk("ovf_cnt", {28'h0, cnt_a}, 32'd8);
    tick();
    chk("ovf_one_cycle", {30'h0, ovf_a, ovfs_a}, {30'h0, 2'b01});

    // ---------------- A: drain 8 ----------------
    for (int i = 1; i <= 8; i++) begin
      rd_a = 1'b1; q_a.push_back(16'(i));
      tick();
      chk("drain_cnt", {28'h0, cnt_a}, 32'(8 - i));
      chk("drain_flags", {30'h0, ae_a, empty_a}, {30'h0, (i == 7), (i == 8)});
    end
    tick();
    rd_a = 1'b0;
    chk("udf_pulse", {29'h0, udf_a, dv_a, udfs_a}, {29'h0, 3'b101});
    chk("udf_hold_dout", {16'h0, dout_a}, 32'h8);

    // ---------------- A: simultaneous at count 3 ----------------
    for (int i = 0; i < 3; i++) begin
      wr_a = 1'b1; din_a = 16'h10 + 16'(i);
      tick();
    end
    din_a = 16'h13; rd_a = 1'b1; q_a.push_back(16'h10);
    tick();
    rd_a = 1'b0;
    chk("sim3_cnt_ack", {27'h0, cnt_a, ack_a}, {27'h0, 4'd3, 1'b1});
    for (int i = 0; i < 5; i++) begin
      din_a = 16'h14 + 16'(i);
      tick();
    end
    chk("refill_full", {27'h0, cnt_a, full_a}, {27'h0, 4'd8, 1'b1});
    // simultaneous at full: read wins, write rejected
    din_a = 16'h99; rd_a = 1'b1; q_a.push_back(16'h11);
    tick();
    wr_a = 1'b0;
    chk("simfull", {26'h0, cnt_a, ovf_a, ack_a}, {26'h0, 4'd7, 1'b1, 1'b0});
    for (int i = 0; i < 7; i++) begin
      q_a.push_back(16'h12 + 16'(i));
      tick();
    end
    rd_a = 1'b0;
    chk("drained_empty", {31'h0, empty_a}, 32'd1);
    // simultaneous at empty: write wins, read rejected
    wr_a = 1'b1; rd_a = 1'b1; din_a = 16'h21;
    tick();
    wr_a = 1'b0; rd_a = 1'b0;
    chk("simempty", {25'h0, cnt_a, udf_a, ack_a, dv_a}, {25'h0, 4'd1, 3'b110});

    // ---------------- A: flush ----------------
    for (int i = 0; i < 3; i++) begin
      wr_a = 1'b1; din_a = 16'h22 + 16'(i);
      tick();
    end
    chk("preflush_cnt", {28'h0, cnt_a}, 32'd4);
    flush_a = 1'b1; din_a = 16'h55;
    tick();
    flush_a = 1'b0; wr_a = 1'b0;
    chk("flush", {25'h0, cnt_a, empty_a, ack_a, ovfs_a}, {25'h0, 4'd0, 3'b101});

    // ---------------- A: err_clr vs overflow ----------------
    for (int i = 0; i < 8; i++) begin
      wr_a = 1'b1; din_a = 16'h30 + 16'(i);
      tick();
    end
    clr_a = 1'b1; din_a = 16'h38;
    tick();
    wr_a = 1'b0;
    chk("clr_vs_ovf", {30'h0, ovf_a, ovfs_a}, {30'h0, 2'b11});
    tick();
    clr_a = 1'b0;
    chk("clr_only", {30'h0, ovfs_a, udfs_a}, 32'd0);

    // ---------------- A: reset mid-burst ----------------
    wr_a = 1'b1; rd_a = 1'b1; q_a.push_back(16'h30);
    tick();
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst", {cnt_a, empty_a, dv_a, ack_a, ovf_a, udf_a, full_a, ovfs_a},
        {4'd0, 1'b1, 6'b0});
    chk("midrst_dout", {16'h0, dout_a}, 32'h0);
    wr_a = 1'b0; rd_a = 1'b0;
    #2 rst_n = 1'b1;
    tick();
    chk("post_rst_cnt", {27'h0, cnt_a, empty_a}, {27'h0, 4'd0, 1'b1});

    // ---------------- B: FWFT single word ----------------
    wr_b = 1'b1; din_b = 16'hABCD;
    tick();
    wr_b = 1'b0;
    chk("fwft_valid", {31'h0, dv_b}, 32'd1);
    chk("fwft_dout", {16'h0, dout_b}, 32'hABCD);
    rd_b = 1'b1; q_b.push_back(16'hABCD);
    tick();
    rd_b = 1'b0;
    chk("fwft_popped", {30'h0, dv_b, empty_b}, {30'h0, 2'b01});

    // ---------------- B: depth-5 interleave with wrap ----------------
    for (int i = 0; i < 12; i++) begin
      wr_b = 1'b1; din_b = 16'h100 + 16'(i);
      rd_b = (i >= 3);
      if (i >= 3) q_b.push_back(16'h100 + 16'(i - 3));
      tick();
      chk("wrap_cnt_max", {31'h0, (cnt_b <= 3'd5)}, 32'd1);
    end
    wr_b = 1'b0;
    chk("wrap_cnt", {29'h0, cnt_b}, 32'd3);
    for (int i = 9; i < 12; i++) begin
      rd_b = 1'b1; q_b.push_back(16'h100 + 16'(i));
      tick();
    end
    rd_b = 1'b0;
    for (int i = 0; i < 5; i++) begin
      wr_b = 1'b1; din_b = 16'h200 + 16'(i);
      tick();
    end
    wr_b = 1'b0;
    chk("b_full", {27'h0, cnt_b, full_b, af_b}, {27'h0, 3'd5, 2'b10});
    for (int i = 0; i < 5; i++) begin
      rd_b = 1'b1; q_b.push_back(16'h200 + 16'(i));
      tick();
    end
    rd_b = 1'b0;
    chk("b_empty", {30'h0, empty_b, dv_b}, {30'h0, 2'b10});

    tick(); tick();
    chk("q_a_drained", 32'(q_a.size()), 32'd0);
    chk("q_b_drained", 32'(q_b.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
